sw_debouncer: RTL and testbench
===============================

# sw_debouncer

Debounces and synchronises the K-bit slide-switch bus before it reaches the thermometer encoder. In `top`, it sits directly upstream of `thermometer_encoder`, and its `q` drives the encoder's `a` input. The encoder therefore only ever sees a stable, glitch-free code, and each accepted change is flagged with a single-cycle strobe. The whole bus is debounced as one word: a new value is committed only after it has been held unchanged for `DEBOUNCE_CYCLES` consecutive cycles.

## Interface
- `K`, default 7: width of the switch bus; must match the encoder's `K`.
- `DEBOUNCE_CYCLES`, default 8: number of consecutive cycles a synchronised value must be stable before commit; legal range 2 to 65535.
- `clk`  in  1  system clock; all state changes on its rising edge.
- `rst`  in  1  reset, asynchronous and active-high.
- `sw`  in  K  raw switch inputs; asynchronous to `clk`.
- `q`  out  K  debounced value; feeds `thermometer_encoder.a`.
- `changed`  out  1  one-cycle pulse, asserted in the same cycle `q` takes a new value.
- `busy`  out  1  high while a candidate value is being qualified.

## Operation
- Synchroniser: two-stage register chain, `sw` -> `s1` -> `s2`. Only `s2` is used downstream.
- Registers:
  - `q`: committed value.
  - `cand`: candidate value under qualification.
  - `cnt`: stability counter, width `$clog2(DEBOUNCE_CYCLES+1)`, unsigned, never wraps.
  - `state`: current FSM state.
- Reset values:
  - `s1`, `s2`, `cand`, `q` = 0; `cnt` = 0; `state` = STABLE.
  - `changed` = 0; `busy` = 0.
- State STABLE:
  - If `s2 == q`: hold; `cnt` stays 0.
  - If `s2 != q`: `cand <= s2`, `cnt <= 1`, go to SETTLE.
- State SETTLE. Evaluate in priority order, first match wins:
  1. `s2 == q` (the bounce returned to the committed value): `cnt <= 0`, go to STABLE. No commit, no `changed`.
  2. `s2 != cand` (a different new value): `cand <= s2`, `cnt <= 1`, stay in SETTLE. This restarts qualification.
  3. `s2 == cand` and `cnt == DEBOUNCE_CYCLES-1`: `q <= cand`, `changed <= 1`, `cnt <= 0`, go to STABLE.
  4. `s2 == cand` otherwise: `cnt <= cnt+1`.
- `changed` is registered and is 0 in every cycle except the one following a commit edge. It can never be high for two consecutive cycles.
- `busy` is registered and equals (`state == SETTLE`).
- `q` changes only on a commit. It never takes any value other than a qualified `cand`.
- Multi-bit changes are treated as one event. Any bit differing between `s2` and `cand` restarts qualification.
- Asserting `rst` mid-SETTLE discards `cand`, `cnt` and the synchroniser contents immediately; no commit occurs. If `sw` is non-zero after release, a fresh qualification starts once the value has passed through the synchroniser.

## Timing
- Let E0 be the first rising edge at which `s1` captures a new `sw` value, held constant thereafter.
- Edge-by-edge sequence:
  - E1: `s2` takes the new value.
  - E2: `state` becomes SETTLE, `cnt` = 1, `busy` = 1.
  - E(DEBOUNCE_CYCLES+1): `q` updates, `changed` = 1, `busy` = 0.
- Total latency from E0 to the `q` update is `DEBOUNCE_CYCLES+1` edges; with the default 8, that is edge E9.
- Any `s2` change during SETTLE delays the commit to `DEBOUNCE_CYCLES-1` edges after the edge that reloads `cand`.
- A pulse on `sw` shorter than `DEBOUNCE_CYCLES` cycles, which then returns to `q`, never reaches `q`.
- `rst` clears all outputs asynchronously without waiting for `clk`. The first post-reset transition is evaluated on the first rising edge after `rst` deasserts.

## Test plan
- Reset: hold `rst`=1 with `sw`=7'h7F. Required: `q`=0, `changed`=0, `busy`=0 throughout reset, checked without any clock edge.
- Clean step, `DEBOUNCE_CYCLES`=8: `sw` goes 0 -> 7'h55 before E0 and is held. Required:
  - `busy` rises at E2.
  - `q`=7'h55 and `changed`=1 at E9 only.
  - `changed` is back to 0 at E10.
- Bounce rejection: `q`=7'h55, `sw`=7'h54 for 5 cycles, then back to 7'h55. Required: `busy` pulses; `q` stays 7'h55; `changed` never asserts.
- Restart on new candidate: from `q`=0, `sw`=7'h0F for 4 cycles, then 7'h1F and held. Required:
  - `q` never equals 7'h0F.
  - `q`=7'h1F with exactly one `changed` pulse, 7 edges after `cand` reloads to 7'h1F.
- Reset mid-settle: `sw`=7'h3C, assert `rst` when `cnt`=4, release 2 cycles later with `sw` held. Required:
  - `q`=0 during reset.
  - Full `DEBOUNCE_CYCLES+1` edge latency from the first post-reset capture edge before `q`=7'h3C.
- Steady input: `sw` constant at 7'h2A for 50 cycles after its commit. Required: exactly one `changed` pulse in total; `busy`=0 for all 50 cycles.

Source files
------------

// File: rtl/sw_debouncer_if.sv
// sw_debouncer_if: switch-bus side of the debouncer, raw switches in and
// the debounced word, change strobe and qualification flag out.
interface sw_debouncer_if #(
   parameter int K = 7
) ();
   logic [K-1:0] sw;
   logic [K-1:0] q;
   logic         changed;
   logic         busy;
   modport master (output sw, input q, changed, busy);
   modport slave  (input sw, output q, changed, busy);
endinterface

// File: rtl/sw_debouncer.sv
// sw_debouncer: synchronises the switch bus and commits a new word only after it
// has been held unchanged for DEBOUNCE_CYCLES consecutive cycles.
module sw_debouncer #(
   parameter int K               = 7,
   parameter int DEBOUNCE_CYCLES = 8
) (
   input  logic           clk,
   input  logic           rst,
   sw_debouncer_if.slave  bus
);
   localparam int CW = $clog2(DEBOUNCE_CYCLES + 1);
   localparam logic [CW-1:0] LAST = CW'(DEBOUNCE_CYCLES - 1);

   typedef enum logic {STABLE, SETTLE} state_t;

   state_t          state_q, state_d;
   logic [K-1:0]    s1_q, s2_q;
   logic [K-1:0]    cand_q, cand_d;
   logic [K-1:0]    q_q, q_d;
   logic [CW-1:0]   cnt_q, cnt_d;
   logic            changed_q, changed_d;
   logic            busy_q, busy_d;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q   <= STABLE;
         s1_q      <= '0;
         s2_q      <= '0;
         cand_q    <= '0;
         q_q       <= '0;
         cnt_q     <= '0;
         changed_q <= 1'b0;
         busy_q    <= 1'b0;
      end else begin
         state_q   <= state_d;
         s1_q      <= bus.sw;
         s2_q      <= s1_q;
         cand_q    <= cand_d;
         q_q       <= q_d;
         cnt_q     <= cnt_d;
         changed_q <= changed_d;
         busy_q    <= busy_d;
      end
   end

   // A return to the committed word cancels qualification before any candidate test.
   always_comb begin
      state_d   = state_q;
      cand_d    = cand_q;
      q_d       = q_q;
      cnt_d     = cnt_q;
      changed_d = 1'b0;
      if (state_q == STABLE) begin
         if (s2_q != q_q) begin
            cand_d  = s2_q;
            cnt_d   = CW'(1);
            state_d = SETTLE;
         end else begin
            cnt_d = '0;
         end
      end else if (s2_q == q_q) begin
         cnt_d   = '0;
         state_d = STABLE;
      end else if (s2_q != cand_q) begin
         cand_d = s2_q;
         cnt_d  = CW'(1);
      end else if (cnt_q == LAST) begin
         q_d       = cand_q;
         changed_d = 1'b1;
         cnt_d     = '0;
         state_d   = STABLE;
      end else begin
         cnt_d = cnt_q + CW'(1);
      end
      busy_d = (state_d == SETTLE);
   end

   assign bus.q       = q_q;
   assign bus.changed = changed_q;
   assign bus.busy    = busy_q;
endmodule

// File: tb/tb_sw_debouncer.sv
// tb_sw_debouncer: directed scenarios plus random switch activity, each cycle
// compared against a run-length model of the debounce rule.
module tb_sw_debouncer;
   localparam int K = 7;
   localparam int D = 8;

   logic clk = 1'b0;
   logic rst = 1'b0;
   logic clk_en = 1'b0;
   int   checks = 0;
   int   errors = 0;
   int   changed_count = 0;
   int   busy_cnt = 0;
   int   q0f_cnt = 0;

   sw_debouncer_if #(.K(K)) bus ();

   sw_debouncer #(.K(K), .DEBOUNCE_CYCLES(D)) dut (.clk(clk), .rst(rst), .bus(bus));

   always #5 clk = clk_en ? ~clk : clk;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   // Model: a word commits once the last D synchronised samples all equal it and differ from q.
   logic [K-1:0] s1m = '0, s2m = '0, obs = '0, run_val = '0, qm = '0;
   logic         chm = 1'b0, bm = 1'b0;
   int           run_len = 0;

   always @(posedge clk or posedge rst) begin
      if (rst) begin
         s1m = '0; s2m = '0; qm = '0; run_val = '0; run_len = 0; chm = 1'b0; bm = 1'b0;
      end else begin
         obs = s2m;
         s2m = s1m;
         s1m = bus.sw;
         if (obs == run_val) run_len = (run_len < 1000000) ? run_len + 1 : run_len;
         else begin
            run_val = obs;
            run_len = 1;
         end
         chm = 1'b0;
         if (obs != qm && run_len >= D) begin
            qm  = obs;
            chm = 1'b1;
         end
         bm = (obs != qm);
      end
      #1;
      check("model_q", 32'(bus.q), 32'(qm));
      check("model_changed", 32'(bus.changed), 32'(chm));
      check("model_busy", 32'(bus.busy), 32'(bm));
      if (bus.changed === 1'b1) changed_count++;
      if (bus.busy === 1'b1) busy_cnt++;
      if (bus.q === 7'h0F) q0f_cnt++;
   end

   task automatic step(input int n);
      repeat (n) @(posedge clk);
      #2;
   endtask

   int c0, b0, f0, r;

   initial begin
      bus.sw = 7'h7F;
      rst = 1'b1;
      #1;
      check("reset_q", 32'(bus.q), 32'h0);
      check("reset_changed", 32'(bus.changed), 32'h0);
      check("reset_busy", 32'(bus.busy), 32'h0);
      clk_en = 1'b1;
      repeat (3) @(posedge clk);
      @(negedge clk);
      rst = 1'b0;
      bus.sw = '0;
      repeat (4) @(negedge clk);
      // clean step to 7'h55: E0 is the next rising edge
      bus.sw = 7'h55;
      step(2);
      check("step_busy_e1", 32'(bus.busy), 32'h0);
      step(1);
      check("step_busy_e2", 32'(bus.busy), 32'h1);
      step(6);
      check("step_q_e8", 32'(bus.q), 32'h0);
      check("step_changed_e8", 32'(bus.changed), 32'h0);
      step(1);
      check("step_q_e9", 32'(bus.q), 32'h55);
      check("step_changed_e9", 32'(bus.changed), 32'h1);
      step(1);
      check("step_changed_e10", 32'(bus.changed), 32'h0);
      check("step_busy_e10", 32'(bus.busy), 32'h0);
      // bounce rejection
      @(negedge clk);
      c0 = changed_count;
      b0 = busy_cnt;
      bus.sw = 7'h54;
      repeat (5) @(negedge clk);
      bus.sw = 7'h55;
      step(15);
      check("bounce_q", 32'(bus.q), 32'h55);
      check("bounce_no_changed", 32'(changed_count - c0), 32'h0);
      check("bounce_busy_pulsed", 32'(busy_cnt > b0), 32'h1);
      // restart on new candidate, from q = 0
      @(negedge clk);
      bus.sw = 7'h00;
      step(12);
      check("restart_q0", 32'(bus.q), 32'h0);
      @(negedge clk);
      f0 = q0f_cnt;
      bus.sw = 7'h0F;
      repeat (4) @(negedge clk);
      c0 = changed_count;
      bus.sw = 7'h1F;
      step(9);
      check("restart_q_g8", 32'(bus.q), 32'h0);
      step(1);
      check("restart_q_g9", 32'(bus.q), 32'h1F);
      check("restart_changed_g9", 32'(bus.changed), 32'h1);
      step(10);
      check("restart_one_pulse", 32'(changed_count - c0), 32'h1);
      check("restart_never_0f", 32'(q0f_cnt - f0), 32'h0);
      // reset while settling on 7'h3C, after edge E5 the count is 4
      @(negedge clk);
      bus.sw = 7'h3C;
      step(6);
      rst = 1'b1;
      #1;
      check("midrst_q", 32'(bus.q), 32'h0);
      check("midrst_busy", 32'(bus.busy), 32'h0);
      repeat (2) @(negedge clk);
      rst = 1'b0;
      step(9);
      check("midrst_q_f8", 32'(bus.q), 32'h0);
      step(1);
      check("midrst_q_f9", 32'(bus.q), 32'h3C);
      check("midrst_changed_f9", 32'(bus.changed), 32'h1);
      // steady input after commit
      @(negedge clk);
      c0 = changed_count;
      bus.sw = 7'h2A;
      step(10);
      check("steady_q", 32'(bus.q), 32'h2A);
      b0 = busy_cnt;
      step(50);
      check("steady_one_pulse", 32'(changed_count - c0), 32'h1);
      check("steady_busy_low", 32'(busy_cnt - b0), 32'h0);
      check("steady_q_end", 32'(bus.q), 32'h2A);
      // random switch activity with occasional resets
      repeat (600) begin
         @(negedge clk);
         r = $urandom_range(0, 99);
         if (r < 2) begin
            rst = 1'b1;
            @(negedge clk);
            rst = 1'b0;
         end else if (r < 8) bus.sw = K'($urandom_range(0, 127));
         else if (r < 14) bus.sw = bus.sw ^ K'(1 << $urandom_range(0, K - 1));
      end
      step(12);
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule
